wb_req_arbiter: RTL
===================

WB_REQ_ARBITER -- requirements
Module: wb_req_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 360, giving the width of one completion-info payload.
REQ-002 The block SHALL have parameter DEPTH, default 2, giving the number of entries per requester FIFO (power of two, at least 2).
REQ-003 The block SHALL have port clock, input, width 1: rising-edge clock.
REQ-004 The block SHALL have port reset, input, width 1: reset, synchronous, active-high.
REQ-005 The block SHALL have port flush, input, width 1: discards all buffered requests (exception invalidate).
REQ-006 The block SHALL have ports alu_valid (input, 1), alu_ready (output, 1) and alu_info (input, DATA_W) forming the ALU completion push port.
REQ-007 The block SHALL have ports mul_valid (input, 1), mul_ready (output, 1) and mul_info (input, DATA_W) forming the MUL completion push port.
REQ-008 The block SHALL have ports cache_valid (input, 1), cache_ready (output, 1) and cache_info (input, DATA_W) forming the cache completion push port.
REQ-009 The block SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_info (output, DATA_W) forming the single reorder-buffer write port.
REQ-010 The block SHALL have port out_src, output, width 2, identifying the granted source: 0 = ALU, 1 = MUL, 2 = cache; the value 3 is never driven.
REQ-011 The block SHALL have port busy, output, width 1, high when any FIFO is non-empty.

Function
REQ-012 Each source SHALL own a DEPTH-entry FIFO, and a push SHALL occur when x_valid and x_ready are both high at a clock edge.
REQ-013 x_ready SHALL be high exactly when that source's FIFO count is below DEPTH and reset is low, and it SHALL NOT depend on out_ready.
REQ-014 A push to a full FIFO SHALL NOT occur, because ready is low; data presented while ready is low SHALL be ignored.
REQ-015 out_valid SHALL be high whenever at least one FIFO is non-empty and no lock is held, or whenever a lock is held.
REQ-016 out_info and out_src SHALL be driven combinationally from the head entry of the granted FIFO.
REQ-017 Arbitration SHALL be round-robin: candidates are scanned in order rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3), and the first non-empty FIFO wins.
REQ-018 An accept SHALL occur when out_valid and out_ready are both high; on an accept, the winner's FIFO SHALL pop and rr_ptr SHALL become (winner+1) mod 3.
REQ-019 When out_valid is high and out_ready is low, the grant SHALL be locked: out_src and out_info SHALL stay unchanged on following cycles until an accept occurs, even if a source earlier in the round-robin order becomes non-empty.
REQ-020 A push and a pop on the same FIFO in the same cycle SHALL both take effect, leaving the count unchanged and preserving FIFO order.
REQ-021 Latency SHALL be one cycle: a push at edge N makes the entry eligible for out_valid in cycle N+1.
REQ-022 There SHALL be no same-cycle bypass from an input port to the output port.
REQ-023 Throughput SHALL be one accept per cycle across all sources combined.
REQ-024 FIFO read and write pointers SHALL wrap modulo DEPTH; counts SHALL use log2(DEPTH)+1 bits and never exceed DEPTH.
REQ-025 When flush is high at an edge, all FIFO counts and pointers SHALL be cleared, the lock SHALL be released and rr_ptr SHALL be unchanged.
REQ-026 Flush SHALL take priority over a simultaneous push and a simultaneous accept: the pushed entry is dropped, and an accept in that same cycle is still considered delivered.
REQ-027 In the cycle after a flush, out_valid SHALL be 0, busy SHALL be 0 and every x_ready SHALL be 1.

Reset
REQ-028 While reset is high, at the edge all FIFOs SHALL be emptied, rr_ptr SHALL be set to 0 and the lock SHALL be cleared.
REQ-029 While reset is high, x_ready SHALL be 0 for all sources, pushes SHALL be ignored, and out_valid and busy SHALL be 0.
REQ-030 After reset, out_src and out_info SHALL both read 0 while out_valid is 0.
REQ-031 Reset asserted in the middle of a locked transfer SHALL abandon that entry.

Verification
REQ-032 Scenario — simultaneous push: alu, mul and cache push A, M and C in the same cycle after reset, with out_ready held at 1 -> outputs are A (src 0), M (src 1), C (src 2) in three consecutive cycles, then busy = 0.
REQ-033 Scenario — backpressure lock: out_ready = 0 with MUL head M1 granted (rr_ptr = 1), then ALU pushes A1 -> out_src stays 1 and out_info stays M1 for 5 cycles; on out_ready = 1, M1 is accepted, followed next by any cache entry, else A1.
REQ-034 Scenario — full FIFO: with out_ready = 0, ALU pushes in 2 consecutive cycles -> alu_ready = 0 in cycle 3, and a third value presented in cycle 3 never appears at the output.
REQ-035 Scenario — push and pop together: ALU FIFO full, out_ready = 1 and alu_valid held high -> the ALU push is refused in the accept cycle (alu_ready low) and accepted on the next cycle; output order is preserved with no duplicates.
REQ-036 Scenario — flush with push: flush = 1 in the same cycle as a cache push with 3 entries buffered -> the next cycle shows out_valid = 0, busy = 0 and all readies = 1, and no stale entry is ever emitted.
REQ-037 Scenario — reset mid-lock: reset during a locked grant -> out_valid = 0 the following cycle, and the next push arbitrates starting from ALU (rr_ptr = 0).

Source files
------------

// File: rtl/wb_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_req_arbiter
// Description : Three-source completion FIFOs with round-robin, grant-locking
//               arbitration onto a single reorder-buffer write port.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_req_arbiter #(
   parameter int DATA_W = 360,
   parameter int DEPTH  = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [DATA_W-1:0] alu_info,
   input  logic              mul_valid,
   output logic              mul_ready,
   input  logic [DATA_W-1:0] mul_info,
   input  logic              cache_valid,
   output logic              cache_ready,
   input  logic [DATA_W-1:0] cache_info,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_info,
   output logic [1:0]        out_src,
   output logic              busy
);
   localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int c_cnt_w = c_ptr_w + 1;
   localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

   logic [2:0]        w_push_valid;
   logic [DATA_W-1:0] w_push_info [3];
   logic [2:0]        w_ready;
   logic [2:0]        w_push;
   logic [2:0]        w_pop;
   logic [2:0]        w_nonempty;
   logic [3:0]        w_nonempty4;
   logic [DATA_W-1:0] w_head [3];

   logic [1:0] r_rr_ptr;
   logic [1:0] r_lock_src;
   logic       r_lock;
   logic [1:0] w_cand1;
   logic [1:0] w_cand2;
   logic [1:0] w_winner;
   logic [1:0] w_grant;
   logic       w_any;
   logic       w_accept;

   function automatic logic [1:0] f_next(input logic [1:0] s);
      return (s == 2'd2) ? 2'd0 : s + 2'd1;
   endfunction

   assign w_push_valid   = {cache_valid, mul_valid, alu_valid};
   assign w_push_info[0] = alu_info;
   assign w_push_info[1] = mul_info;
   assign w_push_info[2] = cache_info;
   assign alu_ready      = w_ready[0];
   assign mul_ready      = w_ready[1];
   assign cache_ready    = w_ready[2];

   generate
      for (genvar g = 0; g < 3; g++) begin : g_fifo
         logic [DATA_W-1:0]  r_mem [DEPTH];
         logic [c_ptr_w-1:0] r_wr_ptr;
         logic [c_ptr_w-1:0] r_rd_ptr;
         logic [c_cnt_w-1:0] r_count;

         assign w_ready[g]    = !reset && (r_count < c_depth);
         assign w_push[g]     = w_push_valid[g] && w_ready[g];
         assign w_pop[g]      = w_accept && (w_grant == 2'(g));
         assign w_nonempty[g] = (r_count != '0);
         assign w_head[g]     = r_mem[r_rd_ptr];

         always_ff @(posedge clock) begin
            if (w_push[g] && !flush) begin
               r_mem[r_wr_ptr] <= w_push_info[g];
            end
         end

         // Pointers are log2(DEPTH) bits wide, so increments wrap modulo DEPTH.
         always_ff @(posedge clock) begin
            if (reset || flush) begin
               r_wr_ptr <= '0;
               r_rd_ptr <= '0;
               r_count  <= '0;
            end else begin
               if (w_push[g]) begin
                  r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
               end
               if (w_pop[g]) begin
                  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
               end
               case ({w_push[g], w_pop[g]})
                  2'b10:   r_count <= r_count + c_cnt_w'(1);
                  2'b01:   r_count <= r_count - c_cnt_w'(1);
                  default: r_count <= r_count;
               endcase
            end
         end
      end
   endgenerate

   assign w_nonempty4 = {1'b0, w_nonempty};
   assign w_cand1     = f_next(r_rr_ptr);
   assign w_cand2     = f_next(w_cand1);

   always_comb begin
      w_winner = r_rr_ptr;
      if (w_nonempty4[r_rr_ptr]) begin
         w_winner = r_rr_ptr;
      end else if (w_nonempty4[w_cand1]) begin
         w_winner = w_cand1;
      end else if (w_nonempty4[w_cand2]) begin
         w_winner = w_cand2;
      end
   end

   // A held grant keeps the output stable under backpressure.
   assign w_grant   = r_lock ? r_lock_src : w_winner;
   assign w_any     = |w_nonempty;
   assign out_valid = !reset && (r_lock || w_any);
   assign busy      = !reset && w_any;
   assign w_accept  = out_valid && out_ready;
   assign out_src   = out_valid ? w_grant : 2'd0;

   always_comb begin
      out_info = '0;
      if (out_valid) begin
         case (w_grant)
            2'd0:    out_info = w_head[0];
            2'd1:    out_info = w_head[1];
            2'd2:    out_info = w_head[2];
            default: out_info = '0;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_rr_ptr   <= 2'd0;
         r_lock     <= 1'b0;
         r_lock_src <= 2'd0;
      end else begin
         if (w_accept && !flush) begin
            r_rr_ptr <= f_next(w_grant);
         end
         if (flush || w_accept) begin
            r_lock <= 1'b0;
         end else if (out_valid) begin
            r_lock     <= 1'b1;
            r_lock_src <= w_grant;
         end
      end
   end
endmodule
`default_nettype wire
